// File: rtl/qtcore_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qtcore_scan_pkg
// Description : Shared types and chain layout for the qtcore_a1 scan
//               sequencer. This includes the sequencer state encoding, the
//               shift-buffer operating modes and the bit offsets of each
//               architectural field inside the 160-bit scan image.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package qtcore_scan_pkg;

  localparam int SCAN_CHAIN_BITS = 160;

  // Chain layout, LSB = last bit shifted in.
  localparam int STATE_LSB    = 0;
  localparam int STATE_W      = 3;
  localparam int PC_LSB       = 3;
  localparam int PC_W         = 5;
  localparam int IR_LSB       = 8;
  localparam int IR_W         = 8;
  localparam int ACC_LSB      = 16;
  localparam int ACC_W        = 8;
  localparam int MEM_BASE_LSB = 24;
  localparam int MEM_WORDS    = 15;
  localparam int MEM_W        = 8;
  localparam int KEY_W        = 16;
  localparam int KEY_LSB      = SCAN_CHAIN_BITS - KEY_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT_IN  = 3'd2,
    ST_GAP       = 3'd3,
    ST_RUN       = 3'd4,
    ST_SHIFT_OUT = 3'd5,
    ST_UNLOAD    = 3'd6
  } scan_state_e;

  typedef enum logic [2:0] {
    BUF_HOLD        = 3'd0,
    BUF_LOAD_BYTE   = 3'd1,
    BUF_SHIFT_BIT   = 3'd2,
    BUF_UNLOAD_BYTE = 3'd3,
    BUF_CLEAR       = 3'd4
  } buf_mode_e;

  // LSB position of memory word n (its MSB sits at 31 + 8n).
  function automatic int mem_lsb(input int n);
    return MEM_BASE_LSB + MEM_W * n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qtcore_scan_sequencer_scan_shift_buffer.sv
`default_nettype none
// ============================================================================
// Module      : scan_shift_buffer
// Description : CHAIN_BITS-wide image register. Bytes enter at the bottom
//               when loading, single bits are shifted MSB-out / capture-in
//               while scanning, and bytes leave from the top when unloading.
// Ports       : clk_i, rst_n_i  - clock, async active-low reset
//               mode_i          - operating mode for this cycle
//               byte_i          - byte appended in BUF_LOAD_BYTE
//               bit_i           - captured chain bit in BUF_SHIFT_BIT
//               msb_o           - buffer MSB (serial scan data source)
//               top_byte_o      - top byte (unload data)
// Revision    : 1.0 - initial release
// ============================================================================
module scan_shift_buffer
  import qtcore_scan_pkg::*;
#(
  parameter int CHAIN_BITS = SCAN_CHAIN_BITS
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  buf_mode_e  mode_i,
  input  logic [7:0] byte_i,
  input  logic       bit_i,
  output logic       msb_o,
  output logic [7:0] top_byte_o
);

  logic [CHAIN_BITS-1:0] buf_q;
  logic [CHAIN_BITS-1:0] buf_d;

  always_comb begin
    buf_d = buf_q;
    case (mode_i)
      BUF_LOAD_BYTE:   buf_d = {buf_q[CHAIN_BITS-9:0], byte_i};
      BUF_SHIFT_BIT:   buf_d = {buf_q[CHAIN_BITS-2:0], bit_i};
      BUF_UNLOAD_BYTE: buf_d = {buf_q[CHAIN_BITS-9:0], 8'h00};
      BUF_CLEAR:       buf_d = '0;
      default:         buf_d = buf_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign msb_o      = buf_q[CHAIN_BITS-1];
  assign top_byte_o = buf_q[CHAIN_BITS-1 -: 8];

endmodule
`default_nettype wire

// File: rtl/qtcore_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qtcore_scan_sequencer
// Description : Scan host for the qtcore_a1 tile. Accepts a scan image as a
//               byte stream, shifts it into the core chain, runs the core
//               until halt or timeout, shifts the final state back out and
//               streams it as bytes.
// Ports       : clk_in, rst_n_in           - clock, async active-low reset
//               start_in                   - begin a transaction (IDLE only)
//               in_data/in_valid/in_ready  - image byte stream
//               out_data/out_valid/out_ready - result byte stream
//               scan_enable_out, scan_data_out, scan_chain_in - chain port
//               proc_en_out                - core processor enable
//               busy, halted, timeout, run_cycles - status
// Revision    : 1.0 - initial release
// ============================================================================
module qtcore_scan_sequencer
  import qtcore_scan_pkg::*;
#(
  parameter int CHAIN_BITS     = SCAN_CHAIN_BITS,
  parameter int MAX_RUN_CYCLES = 256,
  parameter int MIN_RUN_CYCLES = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [7:0]                        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              scan_enable_out,
  output logic                              scan_data_out,
  input  logic                              scan_chain_in,
  output logic                              proc_en_out,
  output logic                              busy,
  output logic                              halted,
  output logic                              timeout,
  output logic [$clog2(MAX_RUN_CYCLES):0]   run_cycles
);

  localparam int CNT_MAX = (CHAIN_BITS > MAX_RUN_CYCLES) ? CHAIN_BITS : MAX_RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int RC_W    = $clog2(MAX_RUN_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(CHAIN_BITS / 8 - 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CHAIN_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_MIN   = CNT_W'(MIN_RUN_CYCLES);
  localparam logic [CNT_W-1:0] RUN_MAX   = CNT_W'(MAX_RUN_CYCLES);

  scan_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic [RC_W-1:0]   run_cycles_q, run_cycles_d;
  buf_mode_e         buf_mode;
  logic              buf_msb;
  logic [7:0]        buf_top;
  logic [CNT_W-1:0]  run_count;

  scan_shift_buffer #(
    .CHAIN_BITS (CHAIN_BITS)
  ) u_buf (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .mode_i     (buf_mode),
    .byte_i     (in_data),
    .bit_i      (scan_chain_in),
    .msb_o      (buf_msb),
    .top_byte_o (buf_top)
  );

  // In RUN, cnt_q holds completed cycles; run_count includes the current one,
  // so the exit value equals the number of cycles proc_en_out was high.
  assign run_count = cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;
    buf_mode     = BUF_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d      = ST_LOAD;
          cnt_d        = '0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
          run_cycles_d = '0;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          buf_mode = BUF_LOAD_BYTE;
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_SHIFT_IN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SHIFT_IN: begin
        buf_mode = BUF_SHIFT_BIT;
        if (cnt_q == LAST_BIT) begin
          // The captured pre-load state is discarded; the zero fill is what
          // SHIFT_OUT later pushes into the chain.
          buf_mode = BUF_CLEAR;
          state_d  = ST_GAP;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // Halt is tested first so it wins when both conditions coincide.
        if ((run_count >= RUN_MIN) && scan_chain_in) begin
          halted_d     = 1'b1;
          run_cycles_d = RC_W'(run_count);
          state_d      = ST_SHIFT_OUT;
          cnt_d        = '0;
        end else if (run_count == RUN_MAX) begin
          timeout_d    = 1'b1;
          run_cycles_d = RC_W'(run_count);
          state_d      = ST_SHIFT_OUT;
          cnt_d        = '0;
        end else begin
          cnt_d = run_count;
        end
      end
      ST_SHIFT_OUT: begin
        buf_mode = BUF_SHIFT_BIT;
        if (cnt_q == LAST_BIT) begin
          state_d = ST_UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          buf_mode = BUF_UNLOAD_BYTE;
          if (cnt_q == LAST_BYTE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
    end
  end

  // All outputs decode registered state only.
  assign in_ready        = (state_q == ST_LOAD);
  assign out_valid       = (state_q == ST_UNLOAD);
  assign out_data        = out_valid ? buf_top : 8'h00;
  assign scan_enable_out = (state_q == ST_SHIFT_IN) || (state_q == ST_SHIFT_OUT);
  assign scan_data_out   = scan_enable_out & buf_msb;
  assign proc_en_out     = (state_q == ST_RUN);
  assign busy            = (state_q != ST_IDLE);
  assign halted          = halted_q;
  assign timeout         = timeout_q;
  assign run_cycles      = run_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_qtcore_scan_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_qtcore_scan_sequencer
// Description : Bench for qtcore_scan_sequencer with a 160-bit shift-register
//               stand-in for the core chain and a driven halt line in RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qtcore_scan_sequencer;
  import qtcore_scan_pkg::*;

  localparam int NB   = SCAN_CHAIN_BITS;
  localparam int NBY  = NB / 8;
  localparam int MAXR = 256;
  localparam int RCW  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           start;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic           scan_en;
  logic           scan_do;
  logic           scan_ci;
  logic           proc_en;
  logic           busy;
  logic           halted;
  logic           timeout;
  logic [RCW-1:0] run_cycles;

  logic [NB-1:0]  stub;
  logic [NB-1:0]  stub_init;
  logic           stub_load = 1'b0;
  logic           halt_drv = 1'b0;
  int             halt_at = 0;
  int             run_idx = 0;

  logic [7:0]     img [NBY];
  logic [NB-1:0]  img_vec;
  logic [7:0]     sb_q [$];

  int total = 0;
  int bad   = 0;

  qtcore_scan_sequencer dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .start_in        (start),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .scan_enable_out (scan_en),
    .scan_data_out   (scan_do),
    .scan_chain_in   (scan_ci),
    .proc_en_out     (proc_en),
    .busy            (busy),
    .halted          (halted),
    .timeout         (timeout),
    .run_cycles      (run_cycles)
  );

  // Chain stand-in: shifts only while scan is enabled; outside scan the
  // chain output doubles as the halt line.
  assign scan_ci = scan_en ? stub[NB-1] : halt_drv;

  always @(posedge clk) begin
    if (stub_load) stub <= stub_init;
    else if (scan_en) stub <= {stub[NB-2:0], scan_do};
  end

  // halt_drv rises during the halt_at-th RUN cycle (1-based) and stays up.
  always @(negedge clk) begin
    if (proc_en) begin
      run_idx  = run_idx + 1;
      halt_drv = (halt_at != 0) && (run_idx >= halt_at);
    end else begin
      run_idx  = 0;
      halt_drv = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload_stub(input logic [NB-1:0] v);
    stub_init = v;
    stub_load = 1'b1;
    @(posedge clk); #1;
    stub_load = 1'b0;
  endtask

  task automatic build_img_vec;
    for (int i = 0; i < NBY; i++) img_vec[NB-1-8*i -: 8] = img[i];
  endtask

  task automatic pulse_start;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load_image(input bit gaps);
    int guard;
    for (int i = 0; i < NBY; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data  = img[i];
      in_valid = 1'b1;
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      total++;
      if (guard >= 50) begin
        bad++;
        $display("FAIL load_ready byte %0d: in_ready=%b required 1", i, in_ready);
      end
      @(posedge clk); #1;
      sb_q.push_back(img[i]);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_txn(input int h_at, input int exp_run, input bit exp_halt,
                         input bit exp_to, input bit gaps, input bit chk_stub);
    int n;
    int stall;
    logic sd_or;
    logic [7:0] exp;
    halt_at = h_at;
    build_img_vec();
    pulse_start();
    total++;
    if ({busy, in_ready, halted, timeout, run_cycles} !== {1'b1, 1'b1, 2'b00, {RCW{1'b0}}}) begin
      bad++;
      $display("FAIL start_clear: busy/rdy/halt/to/rc=%b%b%b%b/%0d required 1100/0",
               busy, in_ready, halted, timeout, run_cycles);
    end
    load_image(gaps);
    total++;
    if ({in_ready, scan_en} !== 2'b01) begin
      bad++;
      $display("FAIL load_exit: in_ready=%b scan_en=%b required 0 1", in_ready, scan_en);
    end
    // A start pulse here must be ignored.
    start = 1'b1;
    n = 0;
    while (scan_en && n < 400) begin
      n++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
    total++;
    if (n != NB) begin
      bad++;
      $display("FAIL shift_in_len: %0d cycles required %0d", n, NB);
    end
    if (chk_stub) begin
      total++;
      if (stub !== img_vec) begin
        bad++;
        $display("FAIL stub_after_shift_in: %h required %h", stub, img_vec);
      end
    end
    n = 0;
    while (!proc_en && n < 10) begin
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL gap_len: %0d cycles required 2", n);
    end
    n = 0;
    while (proc_en && n < MAXR + 10) begin
      n++;
      @(posedge clk); #1;
    end
    total++;
    if (n != exp_run) begin
      bad++;
      $display("FAIL run_len: %0d cycles required %0d", n, exp_run);
    end
    total++;
    if ({scan_en, halted, timeout, run_cycles} !== {1'b1, exp_halt, exp_to, RCW'(exp_run)}) begin
      bad++;
      $display("FAIL run_status: scan_en/halt/to=%b%b%b rc=%0d required 1%b%b rc=%0d",
               scan_en, halted, timeout, run_cycles, exp_halt, exp_to, exp_run);
    end
    n = 0;
    sd_or = 1'b0;
    while (scan_en && n < 400) begin
      n++;
      sd_or = sd_or | scan_do;
      @(posedge clk); #1;
    end
    total++;
    if (n != NB || sd_or !== 1'b0) begin
      bad++;
      $display("FAIL shift_out: %0d cycles data_or=%b required %0d cycles data_or=0", n, sd_or, NB);
    end
    for (int i = 0; i < NBY; i++) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty byte %0d: queue size 0 required >0", i);
        break;
      end
      exp = sb_q.pop_front();
      total++;
      if ({out_valid, out_data} !== {1'b1, exp}) begin
        bad++;
        $display("FAIL unload byte %0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
      end
      stall = $urandom_range(0, 2);
      out_ready = 1'b0;
      if (stall > 0) begin
        repeat (stall) begin
          @(posedge clk); #1;
        end
        total++;
        if ({out_valid, out_data} !== {1'b1, exp}) begin
          bad++;
          $display("FAIL unload_hold byte %0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, exp);
        end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    total++;
    if ({busy, out_valid, out_data} !== 10'h000) begin
      bad++;
      $display("FAIL unload_end: busy=%b valid=%b data=%h required 0 0 00", busy, out_valid, out_data);
    end
    if (chk_stub) begin
      total++;
      if (stub !== {NB{1'b0}}) begin
        bad++;
        $display("FAIL stub_after_shift_out: %h required 0", stub);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, in_ready, out_valid, scan_en, scan_do, proc_en, halted, timeout} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags: %b required 00000000",
               {busy, in_ready, out_valid, scan_en, scan_do, proc_en, halted, timeout});
    end
    total++;
    if ({out_data, run_cycles} !== {8'h00, {RCW{1'b0}}}) begin
      bad++;
      $display("FAIL reset_values: data=%h rc=%0d required 00 0", out_data, run_cycles);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_loopback;
    preload_stub({NBY{8'hA5}});
    for (int i = 0; i < NBY; i++) img[i] = 8'(i);
    run_txn(0, MAXR, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_shift;
    for (int i = 0; i < NBY; i++) img[i] = 8'($urandom);
    pulse_start();
    load_image(1'b0);
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({scan_en, busy, in_ready, proc_en} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: scan_en/busy/rdy/proc=%b required 0000",
               {scan_en, busy, in_ready, proc_en});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_halt(input int h_at, input int exp_run, input bit exp_to);
    for (int i = 0; i < NBY; i++) img[i] = 8'($urandom);
    run_txn(h_at, exp_run, 1'b1, exp_to, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < NBY; i++) img[i] = 8'($urandom);
    run_txn(7, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NBY; i++) img[i] = ~img[i];
    run_txn(0, MAXR, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_reset_mid_shift();
    test_halt(2, 4, 1'b0);
    test_halt(9, 9, 1'b0);
    test_halt(4, 4, 1'b0);
    test_halt(MAXR, MAXR, 1'b0);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
